queue: RTL and testbench
========================

# queue

First-in/first-out buffer that stores bytes at one end and returns them from the other. It is the companion of the LIFO stack: same push/pop/data_in command interface, same sticky-until-next-command error flag, same one-cycle input registration. It sits between a byte producer and a byte consumer that need ordering preserved. It adds full/empty/count status and supports push and pop in the same cycle.

## Interface
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH = 16 entries, all usable.
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  enqueue request, sampled every edge.
- pop  input  1  dequeue request, sampled every edge.
- data_in  input  DATA_WIDTH  word to enqueue, sampled with push.
- data_out  output  DATA_WIDTH  last dequeued word, registered.
- error  output  1  overflow/underflow flag, registered.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.

## Operation
- Inputs push, pop and data_in are registered once (push_reg, pop_reg, data_reg); all decisions use the registered copies.
- State: wr_ptr, rd_ptr (ADDR_WIDTH, wrap modulo DEPTH naturally), count (ADDR_WIDTH+1), read_data_reg, error_reg.
- push_reg only: not full → mem[wr_ptr] <= data_reg, wr_ptr+1, count+1, error 0; full → no write, error 1.
- pop_reg only: not empty → read_data_reg <= mem[rd_ptr], rd_ptr+1, count-1, error 0; empty → data_out holds, error 1.
- push_reg and pop_reg together:
  - Neither empty nor full: both performed, count unchanged, error 0.
  - Full: both performed; the read returns the old head before the write lands, count stays DEPTH, error 0.
  - Empty: push performed (count 1). Pop is an underflow: no bypass, data_out holds, error 1.
- Neither: all state holds, including error, which stays set until the next command.
- full, empty and count are decoded from the count register only, never from pointer comparison.
- Reset:
  - count 0, wr_ptr 0, rd_ptr 0.
  - data_out 0, error 0, full 0, empty 1.
  - push_reg, pop_reg and data_reg are cleared, so a command in flight at reset is discarded.
  - Memory contents are not reset.
- Reset has priority over any command in the same cycle.

## Timing
- Command on input at edge N → registered at N → acted on at edge N+1.
- Enqueue latency: data_in at edge N is written at N+1; it becomes poppable by a pop sampled at edge N+1 or later.
- Dequeue latency: pop at edge N gives data_out, count, empty and error valid after edge N+1.
- Back-to-back commands every cycle are supported at full rate; no ready/valid handshake.
- The producer and consumer use full and empty. Status lags requests by two edges, so the producer must account for up to one in-flight command; an overrun is reported via error, never corrupts stored data.

## Structure
- Shared package/include holds the default DATA_WIDTH and ADDR_WIDTH, common to stack and queue.
- Sub-module queue_ram: 2**ADDR_WIDTH × DATA_WIDTH register file with synchronous write (we, waddr, wdata) and asynchronous read (raddr → rdata). The queue top instantiates it.
- Top contains the input registers, pointer/count logic, next-state block and output registers.

## Test plan
- Reset, then idle → data_out 0x00, error 0, empty 1, full 0, count 0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then 3 pops → data_out 0x11, 0x22, 0x33 in order, one edge after each pop is registered; count 3→0; error 0 throughout.
- Fill with 16 pushes of 0x00..0x0F, then push 0xAA:
  - full 1, count 16, error 1.
  - 16 pops return 0x00..0x0F, with 0xAA absent; pointers have wrapped.
- From empty, pop → error 1, data_out unchanged; then a successful push clears error to 0.
- Simultaneous push/pop:
  - With count 5: count stays 5, data_out is the head, error 0.
  - When full: head returned, count 16, new word appended last.
  - When empty: count 1, error 1.
- Push asserted, then reset on the next edge before the write → count 0, empty 1, and a following pop gives error 1.

Source files
------------

// File: rtl/queue_pkg.sv
// queue_pkg: default widths and derived constants shared by the stack and queue.
package queue_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
endpackage

// File: rtl/queue_if.sv
// queue_if: command and status bundle between a byte producer/consumer (master) and the queue (slave).
// push/pop/data_in: commands from master; data_out/error/full/empty/count: status from slave.
interface queue_if;
  import queue_pkg::*;
  logic push;
  logic pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic error;
  logic full;
  logic empty;
  logic [CW-1:0] count;
  modport master (output push, pop, data_in, input data_out, error, full, empty, count);
  modport slave (input push, pop, data_in, output data_out, error, full, empty, count);
endinterface

// File: rtl/queue_ram.sv
// queue_ram: DEPTH x DATA_WIDTH register file, synchronous write, asynchronous read.
// clk: write clock; we/waddr/wdata: write port; raddr/rdata: combinational read port.
module queue_ram
  import queue_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/queue.sv
// queue: byte FIFO with registered commands, sticky error flag and count/full/empty status.
// clk: clock; reset: synchronous active-high; q: slave side of queue_if.
module queue
  import queue_pkg::*;
(
  input logic    clk,
  input logic    reset,
  queue_if.slave q
);
  logic                  r_push, r_pop, r_error;
  logic [DATA_WIDTH-1:0] r_data, r_rdata;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_full, w_empty, w_do_push, w_do_pop, w_err;
  logic [DATA_WIDTH-1:0] w_head;
  assign w_full = r_count == COUNT_FULL;
  assign w_empty = r_count == '0;
  // A pop frees the slot in the same edge, so a full queue still accepts a paired push.
  assign w_do_push = r_push && (!w_full || r_pop);
  assign w_do_pop = r_pop && !w_empty;
  assign w_err = (r_push && !r_pop && w_full) || (r_pop && w_empty);
  queue_ram u_ram (
    .clk   (clk),
    .we    (w_do_push),
    .waddr (r_wr_ptr),
    .wdata (r_data),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_push   <= 1'b0;
      r_pop    <= 1'b0;
      r_data   <= '0;
      r_rdata  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_push <= q.push;
      r_pop  <= q.pop;
      r_data <= q.data_in;
      if (w_do_pop) begin
        r_rdata  <= w_head;
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      if (r_push || r_pop) r_error <= w_err;
    end
  assign q.data_out = r_rdata;
  assign q.error = r_error;
  assign q.full = w_full;
  assign q.empty = w_empty;
  assign q.count = r_count;
endmodule

// File: tb/tb_queue.sv
// tb_queue: directed self-checking bench for the queue FIFO.
module tb_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  queue_if q ();
  queue dut (.clk(clk), .reset(reset), .q(q));
  always #5 clk = ~clk;

  task automatic drive(input logic p, input logic po, input logic [7:0] d);
    @(negedge clk);
    q.push = p;
    q.pop = po;
    q.data_in = d;
  endtask

  task automatic settle();
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset();
    q.push = 1'b0;
    q.pop = 1'b0;
    q.data_in = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (q.data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", q.data_out); end
    total++; if (q.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", q.error); end
    total++; if (q.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", q.empty); end
    total++; if (q.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", q.full); end
    total++; if (q.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", q.count); end
  endtask

  task automatic test_order();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, exp[i]);
    settle();
    total++; if (q.count !== 5'd3) begin bad++; $display("FAIL order_count got=%0d want=3", q.count); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      settle();
      total++; if (q.data_out !== exp[i]) begin bad++; $display("FAIL order_data%0d got=%h want=%h", i, q.data_out, exp[i]); end
      total++; if (q.error !== 1'b0) begin bad++; $display("FAIL order_error%0d got=%b want=0", i, q.error); end
      total++; if (q.count !== 5'(2 - i)) begin bad++; $display("FAIL order_count%0d got=%0d want=%0d", i, q.count, 2 - i); end
    end
  endtask

  task automatic drain16(input logic [7:0] base, input string tag);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total++;
        if (q.data_out !== base + 8'(i - 2)) begin bad++; $display("FAIL %s_pop%0d got=%h want=%h", tag, i - 2, q.data_out, base + 8'(i - 2)); end
      end
      q.push = 1'b0;
      q.pop = i < 16;
      q.data_in = 8'h00;
    end
    total++; if (q.empty !== 1'b1 || q.count !== 5'd0) begin bad++; $display("FAIL %s_drained got=%b/%0d want=1/0", tag, q.empty, q.count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(i));
    drive(1'b1, 1'b0, 8'hAA);
    settle();
    total++; if (q.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", q.full); end
    total++; if (q.count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d want=16", q.count); end
    total++; if (q.error !== 1'b1) begin bad++; $display("FAIL fill_error got=%b want=1", q.error); end
    drain16(8'h00, "fill");
    total++; if (q.error !== 1'b0) begin bad++; $display("FAIL fill_err_after got=%b want=0", q.error); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 8'h00);
    settle();
    total++; if (q.error !== 1'b1) begin bad++; $display("FAIL under_error got=%b want=1", q.error); end
    total++; if (q.data_out !== 8'h0F) begin bad++; $display("FAIL under_data got=%h want=0f", q.data_out); end
    settle();
    total++; if (q.error !== 1'b1) begin bad++; $display("FAIL under_sticky got=%b want=1", q.error); end
    drive(1'b1, 1'b0, 8'h5A);
    settle();
    total++; if (q.error !== 1'b0 || q.count !== 5'd1) begin bad++; $display("FAIL under_clear got=%b/%0d want=0/1", q.error, q.count); end
    drive(1'b0, 1'b1, 8'h00);
    settle();
    total++; if (q.data_out !== 8'h5A) begin bad++; $display("FAIL under_pop got=%h want=5a", q.data_out); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h41 + 8'(i));
    drive(1'b1, 1'b1, 8'h46);
    settle();
    total++; if (q.count !== 5'd5) begin bad++; $display("FAIL both5_count got=%0d want=5", q.count); end
    total++; if (q.data_out !== 8'h41) begin bad++; $display("FAIL both5_data got=%h want=41", q.data_out); end
    total++; if (q.error !== 1'b0) begin bad++; $display("FAIL both5_error got=%b want=0", q.error); end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 8'h00);
    settle();
    total++; if (q.data_out !== 8'h46 || q.count !== 5'd0) begin bad++; $display("FAIL both5_tail got=%h/%0d want=46/0", q.data_out, q.count); end
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'h80 + 8'(i));
    drive(1'b1, 1'b1, 8'h90);
    settle();
    total++; if (q.data_out !== 8'h80) begin bad++; $display("FAIL bothfull_data got=%h want=80", q.data_out); end
    total++; if (q.count !== 5'd16 || q.full !== 1'b1) begin bad++; $display("FAIL bothfull_count got=%0d/%b want=16/1", q.count, q.full); end
    total++; if (q.error !== 1'b0) begin bad++; $display("FAIL bothfull_error got=%b want=0", q.error); end
    drain16(8'h81, "bothfull");
    drive(1'b1, 1'b1, 8'h77);
    settle();
    total++; if (q.count !== 5'd1) begin bad++; $display("FAIL bothempty_count got=%0d want=1", q.count); end
    total++; if (q.error !== 1'b1) begin bad++; $display("FAIL bothempty_error got=%b want=1", q.error); end
    total++; if (q.data_out !== 8'h90) begin bad++; $display("FAIL bothempty_data got=%h want=90", q.data_out); end
    drive(1'b0, 1'b1, 8'h00);
    settle();
    total++; if (q.data_out !== 8'h77 || q.error !== 1'b0) begin bad++; $display("FAIL bothempty_pop got=%h/%b want=77/0", q.data_out, q.error); end
  endtask

  task automatic test_reset_in_flight();
    drive(1'b1, 1'b0, 8'h99);
    @(negedge clk);
    q.push = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (q.count !== 5'd0 || q.empty !== 1'b1) begin bad++; $display("FAIL flight_count got=%0d/%b want=0/1", q.count, q.empty); end
    total++; if (q.data_out !== 8'h00) begin bad++; $display("FAIL flight_data got=%h want=00", q.data_out); end
    drive(1'b0, 1'b1, 8'h00);
    settle();
    total++; if (q.error !== 1'b1) begin bad++; $display("FAIL flight_pop_error got=%b want=1", q.error); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill();
    test_underflow();
    test_simultaneous();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
